cmd_q: RTL and testbench

//  Per-source command queue feeding one source slot of the 2-bus command arbiter.

---
 rtl/cmd_q.sv | 143 ++++++++++++++
 tb/tb_cmd_q.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_q.sv
// Per-source command queue: steers pushed commands into one of two bus FIFOs
// and presents each FIFO head to the 2-bus arbiter, popping on cmd_tkn.
`ifndef CMD_SIZE
`define CMD_SIZE 16
`endif
`ifndef CMD_VALID
`define CMD_VALID 15
`endif

module cmd_q_fifo #(
  parameter int W     = 16,
  parameter int V     = 15,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       under_o,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty;
  logic          pop_ok;

  assign empty   = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL);
  assign pop_ok  = pop_i & ~empty;
  assign under_o = pop_i & empty;
  assign cnt_o   = cnt_q;

  always_comb begin
    head_o    = mem_q[rd_ptr_q];
    head_o[V] = ~empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_i, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module cmd_q #(
  parameter int DEPTH     = 4,
  parameter int STEER_BIT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [`CMD_SIZE-1:0]     push_cmd,
  output logic                     push_rdy,
  output logic [`CMD_SIZE-1:0]     cmd_out_0,
  output logic [`CMD_SIZE-1:0]     cmd_out_1,
  input  logic [1:0]               cmd_tkn,
  output logic [$clog2(DEPTH):0]   cnt_0,
  output logic [$clog2(DEPTH):0]   cnt_1,
  output logic                     err
);
  localparam int W = `CMD_SIZE;
  localparam int V = `CMD_VALID;

  logic         steer;
  logic         push;
  logic         full_0, full_1;
  logic         under_0, under_1;
  logic [W-1:0] wdata;
  logic         err_q, err_d;

  assign steer    = push_cmd[STEER_BIT];
  assign push_rdy = steer ? ~full_1 : ~full_0;
  assign push     = push_cmd[V] & push_rdy & ~rst;

  always_comb begin
    wdata    = push_cmd;
    wdata[V] = 1'b1;
  end

  cmd_q_fifo #(.W(W), .V(V), .DEPTH(DEPTH)) u_fifo_0 (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push & ~steer),
    .data_i  (wdata),
    .pop_i   (cmd_tkn[0]),
    .full_o  (full_0),
    .under_o (under_0),
    .head_o  (cmd_out_0),
    .cnt_o   (cnt_0)
  );

  cmd_q_fifo #(.W(W), .V(V), .DEPTH(DEPTH)) u_fifo_1 (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push & steer),
    .data_i  (wdata),
    .pop_i   (cmd_tkn[1]),
    .full_o  (full_1),
    .under_o (under_1),
    .head_o  (cmd_out_1),
    .cnt_o   (cnt_1)
  );

  assign err_d = err_q | under_0 | under_1;
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
endmodule

// File: tb/tb_cmd_q.sv
// Randomized self-checking bench for cmd_q against a queue-based model.
`ifndef CMD_SIZE
`define CMD_SIZE 16
`endif
`ifndef CMD_VALID
`define CMD_VALID 15
`endif

module tb_cmd_q;
  localparam int W     = `CMD_SIZE;
  localparam int V     = `CMD_VALID;
  localparam int DEPTH = 4;
  localparam int SB    = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] push_cmd;
  logic         push_rdy;
  logic [W-1:0] cmd_out_0, cmd_out_1;
  logic [1:0]   cmd_tkn;
  logic [$clog2(DEPTH):0] cnt_0, cnt_1;
  logic         err;

  cmd_q #(.DEPTH(DEPTH), .STEER_BIT(SB)) dut (
    .clk       (clk),
    .rst       (rst),
    .push_cmd  (push_cmd),
    .push_rdy  (push_rdy),
    .cmd_out_0 (cmd_out_0),
    .cmd_out_1 (cmd_out_1),
    .cmd_tkn   (cmd_tkn),
    .cnt_0     (cnt_0),
    .cnt_1     (cnt_1),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic         err_m;
  logic         rdy_seen, rdy_exp, took;

  function automatic logic [W-1:0] mk(input logic s);
    logic [W-1:0] c;
    c     = W'($urandom);
    c[V]  = 1'b1;
    c[SB] = s;
    return c;
  endfunction

  // Drive one cycle and advance the model by the spec's rules.
  task automatic step(input logic [W-1:0] c, input logic [1:0] t,
                      input logic r);
    bit p0, p1;
    push_cmd = c;
    cmd_tkn  = t;
    rst      = r;
    #1;
    rdy_seen = push_rdy;
    rdy_exp  = c[SB] ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
    took     = 1'b0;
    if (r) begin
      q0.delete();
      q1.delete();
      err_m = 1'b0;
    end else begin
      p0 = t[0] && q0.size() > 0;
      p1 = t[1] && q1.size() > 0;
      if ((t[0] && q0.size() == 0) || (t[1] && q1.size() == 0))
        err_m = 1'b1;
      if (c[V] && rdy_exp) begin
        took = 1'b1;
        if (c[SB]) q1.push_back(c);
        else       q0.push_back(c);
      end
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(mk(1'b0), 2'b00, 1'b1);
    step(mk(1'b1), 2'b11, 1'b1);
    checks++;
    if (cnt_0 !== 0 || cnt_1 !== 0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt_0, cnt_1);
    end
    checks++;
    if (cmd_out_0[V] !== 1'b0 || cmd_out_1[V] !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b%b want 00",
               cmd_out_0[V], cmd_out_1[V]);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: got %b want 0", err);
    end
  endtask

  task automatic test_steer;
    logic [W-1:0] a, b;
    a = mk(1'b0);
    b = mk(1'b1);
    step(a, 2'b00, 1'b0);
    checks++;
    if (cmd_out_0 !== a) begin
      failures++;
      $display("FAIL steer_a: got %h want %h", cmd_out_0, a);
    end
    step(b, 2'b00, 1'b0);
    checks++;
    if (cmd_out_1 !== b) begin
      failures++;
      $display("FAIL steer_b: got %h want %h", cmd_out_1, b);
    end
    checks++;
    if (cnt_0 !== 1 || cnt_1 !== 1) begin
      failures++;
      $display("FAIL steer_cnt: got %0d/%0d want 1/1", cnt_0, cnt_1);
    end
    step('0, 2'b11, 1'b0);
  endtask

  task automatic test_full;
    logic [W-1:0] c[5];
    for (int i = 0; i < 5; i++) c[i] = mk(1'b0);
    for (int i = 0; i < 4; i++) step(c[i], 2'b00, 1'b0);
    step(c[4], 2'b00, 1'b0);
    checks++;
    if (rdy_seen !== 1'b0 || cnt_0 !== 4) begin
      failures++;
      $display("FAIL full_rdy: got rdy=%b cnt=%0d want rdy=0 cnt=4",
               rdy_seen, cnt_0);
    end
    step(c[4], 2'b01, 1'b0);
    checks++;
    if (rdy_seen !== 1'b0 || cnt_0 !== 3) begin
      failures++;
      $display("FAIL full_nobypass: got rdy=%b cnt=%0d want rdy=0 cnt=3",
               rdy_seen, cnt_0);
    end
    step(c[4], 2'b00, 1'b0);
    checks++;
    if (rdy_seen !== 1'b1 || cnt_0 !== 4) begin
      failures++;
      $display("FAIL full_accept: got rdy=%b cnt=%0d want rdy=1 cnt=4",
               rdy_seen, cnt_0);
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (cmd_out_0 !== c[i]) begin
        failures++;
        $display("FAIL full_order%0d: got %h want %h", i, cmd_out_0, c[i]);
      end
      step('0, 2'b01, 1'b0);
    end
  endtask

  task automatic test_wrap;
    logic [W-1:0] c;
    c = mk(1'b1);
    step(c, 2'b00, 1'b0);
    for (int i = 0; i < 9; i++) begin
      c = mk(1'b1);
      step(c, 2'b10, 1'b0);
      checks++;
      if (cnt_1 !== 1 || cmd_out_1 !== c) begin
        failures++;
        $display("FAIL wrap%0d: got cnt=%0d out=%h want cnt=1 out=%h",
                 i, cnt_1, cmd_out_1, c);
      end
    end
    step('0, 2'b10, 1'b0);
  endtask

  task automatic test_dual;
    step(mk(1'b0), 2'b00, 1'b0);
    step(mk(1'b0), 2'b00, 1'b0);
    step(mk(1'b1), 2'b00, 1'b0);
    step(mk(1'b0), 2'b11, 1'b0);
    checks++;
    if (cnt_0 !== 2 || cnt_1 !== 0 || cmd_out_1[V] !== 1'b0) begin
      failures++;
      $display("FAIL dual: got cnt=%0d/%0d v1=%b want 2/0 v1=0",
               cnt_0, cnt_1, cmd_out_1[V]);
    end
    checks++;
    if (cmd_out_0 !== q0[0]) begin
      failures++;
      $display("FAIL dual_head: got %h want %h", cmd_out_0, q0[0]);
    end
    step('0, 2'b01, 1'b0);
    step('0, 2'b01, 1'b0);
  endtask

  task automatic test_err_reset;
    for (int i = 0; i < 3; i++) step(mk(1'b0), 2'b00, 1'b0);
    step('0, 2'b10, 1'b0);
    checks++;
    if (err !== 1'b1 || cnt_0 !== 3 || cnt_1 !== 0) begin
      failures++;
      $display("FAIL err_set: got err=%b cnt=%0d/%0d want 1 3/0",
               err, cnt_0, cnt_1);
    end
    step('0, 2'b00, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    step(mk(1'b0), 2'b01, 1'b1);
    checks++;
    if (err !== 1'b0 || cnt_0 !== 0 || cmd_out_0[V] !== 1'b0) begin
      failures++;
      $display("FAIL err_reset: got err=%b cnt=%0d v0=%b want 0 0 0",
               err, cnt_0, cmd_out_0[V]);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] pend;
    logic [1:0]   t;
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pend[V] && $urandom_range(0, 3) != 0) pend = mk(1'($urandom));
      t = 2'($urandom);
      if (t[0] && q0.size() == 0 && $urandom_range(0, 7) != 0) t[0] = 1'b0;
      if (t[1] && q1.size() == 0 && $urandom_range(0, 7) != 0) t[1] = 1'b0;
      step(pend, t, ($urandom_range(0, 99) == 0));
      if (took || rst) pend = '0;
      if (!rst) begin
        checks++;
        if (rdy_seen !== rdy_exp) begin
          failures++;
          $display("FAIL rnd_rdy@%0d: got %b want %b", n, rdy_seen, rdy_exp);
        end
      end
      checks++;
      if (cnt_0 !== q0.size() || cnt_1 !== q1.size()) begin
        failures++;
        $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d",
                 n, cnt_0, cnt_1, q0.size(), q1.size());
      end
      checks++;
      if (err !== err_m) begin
        failures++;
        $display("FAIL rnd_err@%0d: got %b want %b", n, err, err_m);
      end
      checks++;
      if (q0.size() > 0 ? (cmd_out_0 !== q0[0]) : (cmd_out_0[V] !== 1'b0)) begin
        failures++;
        $display("FAIL rnd_head0@%0d: got %h want %h", n, cmd_out_0,
                 q0.size() > 0 ? q0[0] : '0);
      end
      checks++;
      if (q1.size() > 0 ? (cmd_out_1 !== q1[0]) : (cmd_out_1[V] !== 1'b0)) begin
        failures++;
        $display("FAIL rnd_head1@%0d: got %h want %h", n, cmd_out_1,
                 q1.size() > 0 ? q1[0] : '0);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    push_cmd = '0;
    cmd_tkn  = '0;
    err_m    = 1'b0;
    @(posedge clk);
    #1;
    test_reset;
    test_steer;
    test_full;
    test_wrap;
    test_dual;
    test_err_reset;
    step('0, 2'b00, 1'b1);
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
